// File: rtl/sid_note_sequencer_if.sv
// sid_note_sequencer_if: host table/control port plus sid_top voice outputs.
// master = host (table writes, start/stop/loop, cfg bytes); slave = sequencer.
interface sid_note_sequencer_if #(
   parameter int AW = 4
);
   logic          wr_en;
   logic [AW-1:0] wr_addr;
   logic [35:0]   wr_data;
   logic          start;
   logic          stop;
   logic          loop;
   logic [7:0]    cfg_attack;
   logic [7:0]    cfg_sustain;
   logic [15:0]   cfg_duration;
   logic [15:0]   frequency;
   logic [7:0]    waveform;
   logic [7:0]    attack;
   logic [7:0]    sustain;
   logic [15:0]   duration;
   logic          busy;
   logic [AW-1:0] note_idx;
   logic          done;

   modport master (
      output wr_en, wr_addr, wr_data, start, stop, loop,
      output cfg_attack, cfg_sustain, cfg_duration,
      input  frequency, waveform, attack, sustain, duration,
      input  busy, note_idx, done
   );

   modport slave (
      input  wr_en, wr_addr, wr_data, start, stop, loop,
      input  cfg_attack, cfg_sustain, cfg_duration,
      output frequency, waveform, attack, sustain, duration,
      output busy, note_idx, done
   );
endinterface

// File: rtl/sid_note_sequencer.sv
// sid_note_sequencer: plays a host-written note table on one sid_top voice.
// Ports: clk, rst (async, active-high), io_bus (slave: table write, start/stop/
// loop, cfg bytes in; frequency/waveform/ADSR/busy/note_idx/done out).
// Option: define SEQ_LOOP_EN to honour the loop input (wrap to entry 0).
module sid_note_sequencer #(
   parameter int TICK_DIV = 50000,
   parameter int DEPTH    = 16,
   parameter int AW       = 4
) (
   input logic                 clk,
   input logic                 rst,
   sid_note_sequencer_if.slave io_bus
);
   localparam int CW = $clog2(TICK_DIV);

   typedef enum logic [1:0] {
      S_IDLE,
      S_GATE_ON,
      S_GATE_OFF
   } state_t;

   state_t        r_state;
   logic [35:0]   r_table [DEPTH];
   logic [CW-1:0] r_cyc;
   logic [7:0]    r_tick;
   logic [7:0]    r_gate_ticks;
   logic [7:0]    r_note_ticks;
   logic [15:0]   r_freq;
   logic [3:0]    r_wave;
   logic          r_gate;
   logic [7:0]    r_attack;
   logic [7:0]    r_sustain;
   logic [15:0]   r_duration;
   logic [AW-1:0] r_idx;
   logic          r_done;

   logic [AW-1:0] w_next_idx;
   logic [AW-1:0] w_fetch_idx;
   logic [35:0]   w_fetch_ent;
   logic [7:0]    w_tick_nxt;
   logic          w_tick_end;
   logic          w_note_end;
   logic          w_gate_end;
   logic          w_launch;
   logic          w_load;
   logic          w_last;

   // Table has no reset; contents are undefined until the host writes them.
   always_ff @(posedge clk) begin
      if (io_bus.wr_en)
         r_table[io_bus.wr_addr] <= io_bus.wr_data;
   end

   always_comb begin
      w_tick_end = (r_cyc == CW'(TICK_DIV - 1));
      w_tick_nxt = r_tick + 8'd1;
      w_note_end = (r_state != S_IDLE) && w_tick_end &&
                   (w_tick_nxt == r_note_ticks);
      w_gate_end = (r_state == S_GATE_ON) && w_tick_end &&
                   (w_tick_nxt == r_gate_ticks);
      w_launch   = (r_state == S_IDLE) && io_bus.start && !io_bus.stop;
      w_load     = w_launch || w_note_end;
      w_next_idx = r_idx + AW'(1);
      if (r_state == S_IDLE) begin
         w_fetch_idx = '0;
         w_fetch_ent = r_table[0];
         w_last      = (r_table[0][35:28] == 8'd0);
      end else begin
         w_fetch_idx = w_next_idx;
         w_fetch_ent = r_table[w_next_idx];
         // End marker, or the index would wrap past the last entry.
         w_last      = (w_fetch_ent[35:28] == 8'd0) ||
                       (r_idx == AW'(DEPTH - 1));
`ifdef SEQ_LOOP_EN
         if (w_last && io_bus.loop) begin
            w_fetch_idx = '0;
            w_fetch_ent = r_table[0];
            w_last      = (r_table[0][35:28] == 8'd0);
         end
`endif
      end
   end

`ifndef SEQ_LOOP_EN
   logic w_loop_unused;
   assign w_loop_unused = io_bus.loop;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state      <= S_IDLE;
         r_cyc        <= '0;
         r_tick       <= '0;
         r_gate_ticks <= '0;
         r_note_ticks <= '0;
         r_freq       <= '0;
         r_wave       <= '0;
         r_gate       <= 1'b0;
         r_attack     <= '0;
         r_sustain    <= '0;
         r_duration   <= '0;
         r_idx        <= '0;
         r_done       <= 1'b0;
      end else begin
         r_done <= 1'b0;
         if (io_bus.stop) begin
            r_state <= S_IDLE;
            r_gate  <= 1'b0;
         end else if (w_load) begin
            if (w_launch) begin
               r_attack   <= io_bus.cfg_attack;
               r_sustain  <= io_bus.cfg_sustain;
               r_duration <= io_bus.cfg_duration;
            end
            if (w_last) begin
               // Frequency and wave nibble deliberately hold.
               r_state <= S_IDLE;
               r_gate  <= 1'b0;
               r_done  <= 1'b1;
            end else begin
               r_freq       <= w_fetch_ent[15:0];
               r_wave       <= w_fetch_ent[19:16];
               r_gate_ticks <= w_fetch_ent[27:20];
               r_note_ticks <= w_fetch_ent[35:28];
               r_gate       <= (w_fetch_ent[27:20] != 8'd0);
               r_cyc        <= '0;
               r_tick       <= '0;
               r_idx        <= w_fetch_idx;
               r_state      <= (w_fetch_ent[27:20] != 8'd0) ?
                               S_GATE_ON : S_GATE_OFF;
            end
         end else if (r_state != S_IDLE) begin
            if (w_tick_end) begin
               r_cyc  <= '0;
               r_tick <= w_tick_nxt;
            end else begin
               r_cyc <= r_cyc + CW'(1);
            end
            if (w_gate_end) begin
               r_gate  <= 1'b0;
               r_state <= S_GATE_OFF;
            end
         end
      end
   end

   assign io_bus.frequency = r_freq;
   assign io_bus.waveform  = {r_wave, 3'b000, r_gate};
   assign io_bus.attack    = r_attack;
   assign io_bus.sustain   = r_sustain;
   assign io_bus.duration  = r_duration;
   assign io_bus.busy      = (r_state != S_IDLE);
   assign io_bus.note_idx  = r_idx;
   assign io_bus.done      = r_done;
endmodule

// File: tb/tb_sid_note_sequencer.sv
// tb_sid_note_sequencer: directed vectors, corner sequences and randomized
// tables checked against a note-timeline reference model.
module tb_sid_note_sequencer;
   localparam int TD    = 4;
   localparam int DEPTH = 4;
   localparam int AW    = 2;
   localparam logic [35:0] Z = 36'd0;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   sid_note_sequencer_if #(.AW(AW)) bus ();

   sid_note_sequencer #(
      .TICK_DIV(TD),
      .DEPTH   (DEPTH),
      .AW      (AW)
   ) dut (
      .clk   (clk),
      .rst   (rst),
      .io_bus(bus)
   );

   typedef struct packed {
      logic [DEPTH-1:0][35:0] e;
      logic                   lp;
      int                     len;
      int                     hi;
      int                     f;
   } vec_t;

   typedef struct packed {
      logic [15:0]   f;
      logic [7:0]    w;
      logic [AW-1:0] idx;
      logic          busy;
      logic          done;
   } exp_t;

   int n_chk  = 0;
   int n_pass = 0;

   logic [35:0]   m_tab [DEPTH];
   logic [15:0]   m_f;
   logic [3:0]    m_w;
   logic [AW-1:0] m_i;
   bit            m_fin;
   exp_t          q[$];
   vec_t          vt [5];

   task automatic chk(input string nm, input logic [63:0] got,
                      input logic [63:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s got %0h exp %0h at %0t", nm, got, exp, $time);
   endtask

   function automatic logic [35:0] ent(input int f, input int w,
                                       input int g, input int n);
      return {8'(n), 8'(g), 4'(w), 16'(f)};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input int a, input logic [35:0] d);
      bus.wr_en   = 1'b1;
      bus.wr_addr = AW'(a);
      bus.wr_data = d;
      step();
      bus.wr_en = 1'b0;
      m_tab[a]  = d;
   endtask

   task automatic load(input logic [DEPTH-1:0][35:0] t);
      for (int a = 0; a < DEPTH; a++) wr(a, t[a]);
   endtask

   task automatic go();
      bus.start = 1'b1;
      step();
      bus.start = 1'b0;
   endtask

   task automatic rst_dut();
      rst = 1'b1;
      step();
      rst = 1'b0;
      m_f = '0;
      m_w = '0;
      m_i = '0;
   endtask

   function automatic logic [63:0] outs();
      return 64'({bus.frequency, bus.waveform, bus.attack, bus.sustain,
                  bus.duration, bus.busy, bus.done, bus.note_idx});
   endfunction

   function automatic logic [63:0] trace_now();
      return 64'({bus.frequency, bus.waveform, bus.note_idx,
                  bus.busy, bus.done});
   endfunction

   // Expected per-cycle timeline: each note expands to note_ticks*TD cycles,
   // gate high for the first gate_ticks*TD of them, then a done cycle.
   task automatic build(input bit lp, input int budget);
      bit   lpe;
      int   i;
      int   nt;
      int   gt;
      bit   endc;
      logic gb;
      lpe = lp;
`ifndef SEQ_LOOP_EN
      lpe = 1'b0;
`endif
      q.delete();
      i     = 0;
      m_fin = (m_tab[0][35:28] == 8'd0);
      while (!m_fin && q.size() < budget) begin
         nt  = int'(m_tab[i][35:28]);
         gt  = int'(m_tab[i][27:20]);
         m_f = m_tab[i][15:0];
         m_w = m_tab[i][19:16];
         m_i = AW'(i);
         for (int c = 0; c < nt * TD && q.size() < budget; c++) begin
            gb = (gt != 0) && (c < gt * TD);
            q.push_back('{m_f, {m_w, 3'b000, gb}, m_i, 1'b1, 1'b0});
         end
         if (q.size() >= budget) break;
         i++;
         endc = (i == DEPTH) ? 1'b1 : (m_tab[i][35:28] == 8'd0);
         if (endc) begin
            if (lpe && m_tab[0][35:28] != 8'd0) i = 0;
            else m_fin = 1'b1;
         end
      end
      if (m_fin) begin
         q.push_back('{m_f, {m_w, 4'b0000}, m_i, 1'b0, 1'b1});
         q.push_back('{m_f, {m_w, 4'b0000}, m_i, 1'b0, 1'b0});
      end
   endtask

   task automatic run_model(input bit lp);
      logic [7:0]  a0;
      logic [7:0]  s0;
      logic [15:0] d0;
      exp_t        e;
      int          n;
      a0       = bus.cfg_attack;
      s0       = bus.cfg_sustain;
      d0       = bus.cfg_duration;
      bus.loop = lp;
      build(lp, 120);
      go();
      bus.cfg_attack   = 8'($urandom);
      bus.cfg_sustain  = 8'($urandom);
      bus.cfg_duration = 16'($urandom);
      n = q.size();
      for (int k = 0; k < n; k++) begin
         e = q[k];
         chk("trace", trace_now(), 64'(e));
         bus.start = e.busy && ($urandom_range(0, 7) == 0);
         if (k == n - 1 && !m_fin) bus.stop = 1'b1;
         step();
         bus.start = 1'b0;
         bus.stop  = 1'b0;
      end
      if (!m_fin)
         chk("rand_stop", trace_now(),
             64'({m_f, m_w, 4'b0000, m_i, 2'b00}));
      chk("cfg_latch", 64'({bus.attack, bus.sustain, bus.duration}),
          64'({a0, s0, d0}));
      bus.loop = 1'b0;
   endtask

   initial begin
      logic [DEPTH-1:0][35:0] t;
      int len;
      int hi;

      vt[0] = '{e: {Z, Z, Z, ent(148, 2, 2, 3)},
                lp: 1'b0, len: 12, hi: 8, f: 148};
      vt[1] = '{e: {Z, Z, ent(200, 4, 5, 1), ent(100, 1, 0, 2)},
                lp: 1'b0, len: 12, hi: 4, f: 100};
`ifdef SEQ_LOOP_EN
      vt[2] = '{e: {ent(10, 1, 1, 1), ent(10, 1, 1, 1),
                    ent(10, 1, 1, 1), ent(10, 1, 1, 1)},
                lp: 1'b1, len: -1, hi: 100, f: 10};
`else
      vt[2] = '{e: {ent(10, 1, 1, 1), ent(10, 1, 1, 1),
                    ent(10, 1, 1, 1), ent(10, 1, 1, 1)},
                lp: 1'b1, len: 16, hi: 16, f: 10};
`endif
      vt[3] = '{e: {ent(10, 1, 1, 1), ent(10, 1, 1, 1),
                    ent(10, 1, 1, 1), Z},
                lp: 1'b0, len: 0, hi: 0, f: 10};
      vt[4] = '{e: {ent(4, 4, 2, 1), ent(3, 3, 1, 2),
                    ent(2, 2, 0, 1), ent(1, 1, 3, 2)},
                lp: 1'b0, len: 24, hi: 16, f: 1};

      rst              = 1'b1;
      bus.wr_en        = 1'b0;
      bus.wr_addr      = '0;
      bus.wr_data      = '0;
      bus.start        = 1'b0;
      bus.stop         = 1'b0;
      bus.loop         = 1'b0;
      bus.cfg_attack   = 8'h5a;
      bus.cfg_sustain  = 8'ha5;
      bus.cfg_duration = 16'h1234;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      chk("reset", outs(), 64'd0);

      for (int v = 0; v < 5; v++) begin
         load(vt[v].e);
         bus.loop = vt[v].lp;
         go();
         chk("v_freq", 64'(bus.frequency), 64'(vt[v].f));
         chk("v_busy0", 64'(bus.busy), 64'(vt[v].len != 0));
         len = -1;
         hi  = 0;
         for (int k = 0; k < 100; k++) begin
            if (bus.done) begin
               len = k;
               break;
            end
            if (bus.busy && bus.waveform[0]) hi++;
            step();
         end
         if (len < 0) bus.stop = 1'b1;
         step();
         bus.stop = 1'b0;
         bus.loop = 1'b0;
         chk("v_len", 64'(len), 64'(vt[v].len));
         chk("v_gate_hi", 64'(hi), 64'(vt[v].hi));
         chk("v_idle", 64'({bus.busy, bus.done}), 64'd0);
      end

      bus.start = 1'b1;
      bus.stop  = 1'b1;
      step();
      bus.start = 1'b0;
      bus.stop  = 1'b0;
      chk("start_stop", 64'({bus.busy, bus.done, bus.waveform[0]}), 64'd0);
      step();
      chk("start_stop2", 64'({bus.busy, bus.done}), 64'd0);

      load({Z, Z, Z, ent(300, 5, 3, 4)});
      go();
      repeat (5) step();
      chk("pre_stop", 64'({bus.busy, bus.waveform}), 64'({1'b1, 8'h51}));
      bus.stop = 1'b1;
      step();
      bus.stop = 1'b0;
      chk("stop_mid", 64'({bus.busy, bus.done, bus.waveform, bus.frequency}),
          64'({2'b00, 8'h50, 16'd300}));
      step();
      chk("stop_nodone", 64'({bus.busy, bus.done}), 64'd0);

      load({Z, Z, ent(2, 1, 0, 1), ent(1, 1, 1, 1)});
      bus.loop = 1'b1;
      go();
`ifdef SEQ_LOOP_EN
      for (int k = 0; k < 6; k++) begin
         chk("loop_idx", 64'({bus.note_idx, bus.busy, bus.done}),
             64'({AW'(k % 2), 2'b10}));
         repeat (4) step();
      end
      bus.stop = 1'b1;
      step();
      bus.stop = 1'b0;
`else
      repeat (8) step();
      chk("noloop_done", 64'({bus.busy, bus.done}), 64'd1);
      step();
`endif
      bus.loop = 1'b0;

      load({Z, Z, Z, ent(148, 2, 2, 3)});
      go();
      repeat (3) step();
      chk("gate_on", 64'(bus.waveform), 64'h21);
      #2;
      rst = 1'b1;
      #1;
      chk("async_rst", outs(), 64'd0);
      step();
      rst = 1'b0;
      m_f = '0;
      m_w = '0;
      m_i = '0;

      load({Z, Z, ent(6, 1, 1, 1), ent(5, 1, 1, 2)});
      go();
      repeat (2) step();
      wr(1, ent(777, 3, 1, 1));
      repeat (4) step();
      chk("old_note", 64'(bus.frequency), 64'd5);
      step();
      chk("new_note", 64'({bus.frequency, bus.waveform, bus.note_idx}),
          64'({16'd777, 8'h31, AW'(1)}));
      repeat (4) step();
      chk("rewrite_done", 64'({bus.busy, bus.done}), 64'd1);
      step();

      rst_dut();
      for (int r = 0; r < 30; r++) begin
         for (int a = 0; a < DEPTH; a++)
            t[a] = ent(int'($urandom), int'($urandom_range(0, 15)),
                       int'($urandom_range(0, 4)),
                       (a == 0) ? int'($urandom_range(1, 3))
                                : int'($urandom_range(0, 3)));
         if ($urandom_range(0, 9) == 0) t[0][35:28] = 8'd0;
         load(t);
         bus.cfg_attack   = 8'($urandom);
         bus.cfg_sustain  = 8'($urandom);
         bus.cfg_duration = 16'($urandom);
         run_model(1'($urandom_range(0, 1)));
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule

// File: doc/sid_note_sequencer.md
# sid_note_sequencer

Table-driven note sequencer that plays a short melody on one `sid_top` voice without host intervention. It holds up to DEPTH note entries written by a host and steps through them on a prescaled tick. For each note it drives `sid_top`'s `frequency`, `waveform` and gate bit, plus the static `attack`, `sustain` and `duration`. Its outputs connect directly to `sid_top` inputs, upstream of `pwm_audio`.

## Interface
- `TICK_DIV`, default 50000: clocks per sequencer tick (1 ms at 50 MHz); legal range ≥ 2.
- `DEPTH`, default 16: number of note entries; power of two.
- `AW`, default 4: address width, equal to log2(DEPTH).
- `clk`  in  1  system clock.
- `rst`  in  1  reset; one clock, asynchronous, active-high.
- `wr_en`  in  1  table write strobe.
- `wr_addr`  in  AW  entry index.
- `wr_data`  in  36  entry fields:
  - [15:0] freq
  - [19:16] wave nibble, mapped to waveform[7:4]
  - [27:20] gate_ticks
  - [35:28] note_ticks
- `start`  in  1  one-cycle play request.
- `stop`  in  1  one-cycle abort request.
- `loop`  in  1  wrap to entry 0 at end of sequence.
- `cfg_attack`, `cfg_sustain`  in  8 each  ADSR bytes.
- `cfg_duration`  in  16  duration word.
- `frequency`  out  16  to `sid_top`.
- `waveform`  out  8  to `sid_top`.
  - bit 0 is the gate.
  - bits 3:1 are always 0.
- `attack`, `sustain`  out  8  to `sid_top`.
- `duration`  out  16  to `sid_top`.
- `busy`  out  1  high while playing.
- `note_idx`  out  AW  index of the current entry.
- `done`  out  1  one-cycle pulse at sequence end.

## Operation
- Table: register array with combinational read. A write takes effect at the edge where `wr_en` is sampled.
  - Writes are legal at any time.
  - An entry being played keeps its latched values; a rewritten entry is used from its next fetch.
- FSM states: IDLE, GATE_ON, GATE_OFF.
- Entry with note_ticks==0 is the end marker.
- IDLE + `start` + no `stop`:
  - Latch `cfg_*` into `attack`, `sustain`, `duration`.
  - Fetch entry 0.
  - If entry 0 is an end marker: pulse `done`, stay IDLE, `busy` stays 0.
- Fetch of a valid entry, all in one edge:
  - Register `frequency` and waveform[7:4].
  - Gate = 1 if gate_ticks≠0.
  - Clear the tick and cycle counters.
  - Set `note_idx`.
  - Go to GATE_ON, or to GATE_OFF when gate_ticks==0 (rest).
- GATE_ON: when the tick count reaches gate_ticks, clear the gate and go to GATE_OFF. If gate_ticks ≥ note_ticks, the gate stays high for the whole note.
- Note end, after note_ticks ticks:
  - Fetch entry `note_idx`+1, wrapping modulo DEPTH.
  - If that entry is an end marker, or the index wrapped past DEPTH−1: with `loop`=1, fetch entry 0; otherwise go to IDLE, clear the gate and pulse `done`. Frequency and wave nibble hold their last values.
  - If entry 0 is itself an end marker during a loop: stop as above.
- `stop` in any state: go to IDLE, clear the gate, `busy`=0. No `done` pulse. `start` and `stop` in the same cycle: `stop` wins.
- `start` while `busy` is ignored.
- `busy` = (state≠IDLE).

## Timing
- Reset values:
  - all outputs 0
  - state IDLE
  - `note_idx` 0
  - prescaler 0
  - table contents undefined
- Play start: `start` sampled at edge E0 → outputs and gate valid after E0, `busy`=1 after E0. Latency is 1 cycle.
- Gate falls at E0 + gate_ticks·TICK_DIV.
- Each note lasts exactly note_ticks·TICK_DIV cycles.
  - The next entry's outputs change at the edge ending the last cycle.
  - There is no idle gap between notes.
  - Gate rises in the same edge if the next note is gated. A gate-held note followed by a gated note therefore shows no gate low cycle. This is intentional legato.
- The `done` pulse coincides with the edge where `busy` falls.
- `rst` mid-play: immediate return to reset values.

## Configuration
- `SEQ_LOOP_EN` defined: the `loop` input is honoured as described.
- Not defined: `loop` is ignored and the sequence always ends at the end marker or at entry DEPTH−1. The wrap logic is not synthesised.

## Test plan
- TICK_DIV=4. Entries:
  - 0: freq 148, wave 2, gate 2, note 3
  - 1: note 0
  
  Start → `frequency`=148, `waveform`=8'h21 for 8 cycles, then 8'h20 for 4 cycles. `done` pulses at cycle 12 with `busy` falling.
- Entry 0 rest (gate 0, note 2), entry 1 gated (gate 5, note 1), entry 2 end marker → gate 0 for 8 cycles, then 1 for 4 cycles, then `done`.
- `loop`=1 with `SEQ_LOOP_EN`, 2 valid entries → `note_idx` sequence 0,1,0,1…; `done` never pulses. Stop mid-note → gate 0 and `busy` 0 the next cycle, no `done`.
- Without `SEQ_LOOP_EN` and `loop`=1 → plays once, then `done`.
- Entry 0 end marker, then `start` → `done` pulses one cycle after, `busy` stays 0. `start`+`stop` together → nothing happens.
- Async `rst` asserted mid-GATE_ON → all outputs 0 immediately. Rewrite entry 1 during note 0 → the new freq appears at note 1.
